// File: rtl/prescaler_cfg_arbiter.sv
// Round-robin sharing of one Prescaler's new_value input between NREQ config masters.
// Define PRESCALER_ARB_TIMEOUT_EN to abort a grant that sees no terminal-count tick within TIMEOUT cycles.

module prescaler_cfg_arbiter #(
   parameter int          NREQ       = 4,
   parameter logic [31:0] INIT_VALUE = 32'd1,
   parameter int          TIMEOUT    = 256
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic                    run,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*32-1:0]      req_value,
   output logic [NREQ-1:0]         ack,
   output logic [NREQ-1:0]         err,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    psc_en,
   output logic [31:0]             psc_new_value,
   input  logic                    psc_clk_en
);

   localparam int ID_W = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
      $error("prescaler_cfg_arbiter: unsupported NREQ or TIMEOUT");
   end

   typedef enum logic [1:0] {IDLE, WAIT1, WAITN, ACK} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] winner;
   logic [31:0]     committed;
   logic            ld_grant;
   logic            ld_commit;
   logic            do_abort;
   logic            expire;

   // First set request at or after ptr, wrapping around.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [ID_W-1:0] ptr);
      logic [ID_W:0]   idx;
      logic [ID_W-1:0] pick;
      logic            found;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = {1'b0, ptr} + (ID_W+1)'(i);
         if (idx >= (ID_W+1)'(NREQ)) idx = idx - (ID_W+1)'(NREQ);
         if (!found && r[idx[ID_W-1:0]]) begin
            pick  = idx[ID_W-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] w);
      return (w == ID_W'(NREQ - 1)) ? '0 : w + ID_W'(1);
   endfunction

   assign winner = rr_pick(req, rr_ptr);
   assign busy   = (state != IDLE);

   always_comb begin
      state_nxt = state;
      ld_grant  = 1'b0;
      ld_commit = 1'b0;
      do_abort  = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               ld_grant  = 1'b1;
               state_nxt = WAIT1;
            end
         end
         // A tick here may come from a reload that still used the old value.
         WAIT1: begin
            if (expire) begin
               do_abort  = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = WAITN;
            end
         end
         WAITN: begin
            if (psc_clk_en) begin
               ld_commit = 1'b1;
               state_nxt = ACK;
            end else if (expire) begin
               do_abort  = 1'b1;
               state_nxt = IDLE;
            end
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         grant_id      <= '0;
         psc_en        <= 1'b0;
         psc_new_value <= INIT_VALUE;
         committed     <= INIT_VALUE;
         ack           <= '0;
      end else begin
         state  <= state_nxt;
         psc_en <= run;
         ack    <= '0;
         if (ld_grant) begin
            grant_id      <= winner;
            rr_ptr        <= rr_next(winner);
            psc_new_value <= req_value[32*winner +: 32];
         end
         if (ld_commit) begin
            committed <= psc_new_value;
            ack       <= NREQ'(1) << grant_id;
         end
         if (do_abort) psc_new_value <= committed;
      end
   end

`ifdef PRESCALER_ARB_TIMEOUT_EN
   logic [15:0] wait_cnt;
   logic [15:0] wait_cnt_inc;

   assign wait_cnt_inc = wait_cnt + 16'd1;
   // A qualifying tick takes priority over expiry in WAITN.
   assign expire = (state == WAIT1 || state == WAITN) && (wait_cnt_inc >= 16'(TIMEOUT));

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wait_cnt <= '0;
         err      <= '0;
      end else begin
         err <= do_abort ? (NREQ'(1) << grant_id) : '0;
         if (ld_grant)
            wait_cnt <= '0;
         else if (state == WAIT1 || state == WAITN)
            wait_cnt <= wait_cnt_inc;
      end
   end
`else
   assign expire = 1'b0;
   assign err    = '0;
`endif

endmodule

// File: tb/tb_prescaler_cfg_arbiter.sv
// Bench for prescaler_cfg_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-timeline reference model.

module tb_prescaler_cfg_arbiter;

   localparam int          NREQ    = 4;
   localparam int          TIMEOUT = 16;
   localparam logic [31:0] INIT    = 32'd1;
`ifdef PRESCALER_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         arst;
   logic         run;
   logic [3:0]   req;
   logic [127:0] req_value;
   logic [3:0]   ack;
   logic [3:0]   err;
   logic         busy;
   logic [1:0]   grant_id;
   logic         psc_en;
   logic [31:0]  psc_new_value;
   logic         psc_clk_en;

   logic         env_psc;
   logic         tick_drv;
   logic         tick_psc;
   logic [31:0]  psc_cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prescaler_cfg_arbiter #(.NREQ(NREQ), .INIT_VALUE(INIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .arst(arst), .run(run), .req(req), .req_value(req_value),
      .ack(ack), .err(err), .busy(busy), .grant_id(grant_id), .psc_en(psc_en),
      .psc_new_value(psc_new_value), .psc_clk_en(psc_clk_en)
   );

   // Simple Prescaler: reloads new_value at terminal count, registered tick.
   assign psc_clk_en = env_psc ? tick_psc : tick_drv;
   always @(posedge clk or posedge arst) begin
      if (arst) begin
         psc_cnt  <= INIT;
         tick_psc <= 1'b0;
      end else if (psc_en) begin
         if (psc_cnt == 32'd0) begin
            psc_cnt  <= psc_new_value;
            tick_psc <= 1'b1;
         end else begin
            psc_cnt  <= psc_cnt - 32'd1;
            tick_psc <= 1'b0;
         end
      end else begin
         tick_psc <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      arst      = 1'b1;
      req       = '0;
      req_value = '0;
      tick_drv  = 1'b0;
      run       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic wait_ack(output logic [3:0] a, output logic [1:0] g, output logic [31:0] v,
                           output logic prev_t, output bit ok);
      logic prev;
      prev = 1'b0; ok = 1'b0; a = '0; g = '0; v = '0; prev_t = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk); #1;
         if (ack != 4'd0) begin
            a = ack; g = grant_id; v = psc_new_value; prev_t = prev; ok = 1'b1;
            break;
         end
         prev = psc_clk_en;
      end
   endtask

   task automatic tick_gap(output int gap);
      bit seen;
      gap = -1; seen = 1'b0;
      for (int n = 0; n < 64 && !seen; n++) begin
         @(posedge clk); #1;
         seen = psc_clk_en;
      end
      if (seen) begin
         for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (psc_clk_en) begin
               gap = n;
               break;
            end
         end
      end
   endtask

   function automatic int oh2i(input logic [3:0] a);
      for (int i = 0; i < 4; i++) if (a[i]) return i;
      return -1;
   endfunction

   typedef struct {
      logic        run;
      logic [3:0]  req;
      logic        tick;
      logic [3:0]  e_ack;
      logic        e_busy;
      logic [1:0]  e_gid;
      logic [31:0] e_pnv;
      logic        e_en;
   } vec_t;

   vec_t        tbl [14];
   logic [3:0]  a;
   logic [1:0]  g;
   logic [31:0] v;
   logic        pt;
   bit          ok;
   int          gap;
   int          n_at;
   bit          saw_ack;
   bit          any_err;
   int          ids [4];
   int          nids;

   // Reference model state: a transaction timeline indexed by cycle number.
   int          cyc;
   bit          m_active;
   int          m_g, m_id, m_ptr, m_ack_cyc, m_err_cyc;
   logic [31:0] m_val, m_commit;
   bit          pend [4];
   logic [31:0] vals [4];
   logic [3:0]  e_oh;
   logic        e_run;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //               run  req     tick  ack     busy  gid   pnv     en
      tbl[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd3, 1'b1};
      tbl[1]  = '{1'b1, 4'b0001, 1'b1, 4'b0000, 1'b1, 2'd0, 32'd3, 1'b1};
      tbl[2]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd3, 1'b1};
      tbl[3]  = '{1'b1, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd3, 1'b1};
      tbl[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd3, 1'b0};
      tbl[5]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'd3, 1'b1};
      tbl[6]  = '{1'b1, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd1, 32'd7, 1'b1};
      tbl[7]  = '{1'b1, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd1, 32'd7, 1'b1};
      tbl[8]  = '{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b1, 2'd1, 32'd7, 1'b1};
      tbl[9]  = '{1'b1, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd7, 1'b1};
      tbl[10] = '{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0, 2'd1, 32'd7, 1'b1};
      tbl[11] = '{1'b1, 4'b0101, 1'b1, 4'b0000, 1'b1, 2'd2, 32'd9, 1'b1};
      tbl[12] = '{1'b1, 4'b0001, 1'b1, 4'b0000, 1'b1, 2'd2, 32'd9, 1'b1};
      tbl[13] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd2, 32'd9, 1'b1};

      env_psc = 1'b0;
      do_reset();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_pnv", psc_new_value, INIT);
      chk("rst_en", 32'(psc_en), 32'd0);

      req_value = {32'd0, 32'd9, 32'd7, 32'd3};
      for (int k = 0; k < 14; k++) begin
         run = tbl[k].run; req = tbl[k].req; tick_drv = tbl[k].tick;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_ack", k), 32'(ack), 32'(tbl[k].e_ack));
         chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(tbl[k].e_busy));
         chk($sformatf("vec%0d_gid", k), 32'(grant_id), 32'(tbl[k].e_gid));
         chk($sformatf("vec%0d_pnv", k), psc_new_value, tbl[k].e_pnv);
         chk($sformatf("vec%0d_en", k), 32'(psc_en), 32'(tbl[k].e_en));
      end

      // Asynchronous reset while waiting in WAITN with value 9.
      @(negedge clk);
      arst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ack", 32'(ack), 32'd0);
      chk("arst_en", 32'(psc_en), 32'd0);
      chk("arst_pnv", psc_new_value, INIT);
      chk("arst_gid", 32'(grant_id), 32'd0);
      req = '0; tick_drv = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      @(posedge clk); #1;
      chk("arst_idle", 32'(busy), 32'd0);
      tick_drv = 1'b0;

      // Single requester with a live Prescaler: value 3 gives a 4-cycle tick period.
      do_reset();
      env_psc = 1'b1; run = 1'b1;
      req_value[31:0] = 32'd3; req = 4'b0001;
      wait_ack(a, g, v, pt, ok);
      chk("t1_ack_seen", 32'(ok), 32'd1);
      chk("t1_ack", 32'(a), 32'b0001);
      chk("t1_after_tick", 32'(pt), 32'd1);
      chk("t1_pnv", v, 32'd3);
      req = '0;
      tick_gap(gap);
      chk("t1_period", 32'(gap), 32'd4);

      // Two simultaneous requests right after reset.
      do_reset();
      env_psc = 1'b1; run = 1'b1;
      req_value = {32'd0, 32'd0, 32'd7, 32'd5}; req = 4'b0011;
      wait_ack(a, g, v, pt, ok);
      chk("t2_first_seen", 32'(ok), 32'd1);
      chk("t2_first_ack", 32'(a), 32'b0001);
      chk("t2_first_gid", 32'(g), 32'd0);
      chk("t2_first_pnv", v, 32'd5);
      req[0] = 1'b0;
      wait_ack(a, g, v, pt, ok);
      chk("t2_second_seen", 32'(ok), 32'd1);
      chk("t2_second_ack", 32'(a), 32'b0010);
      chk("t2_second_gid", 32'(g), 32'd1);
      chk("t2_second_pnv", v, 32'd7);
      req = '0;
      tick_gap(gap);
      chk("t2_period", 32'(gap), 32'd8);

      // Ticks stopped: abort with err when the timeout exists, otherwise wait forever.
      do_reset();
      env_psc = 1'b0; run = 1'b0;
      req_value[95:64] = 32'd4; req = 4'b0100;
      saw_ack = 1'b0; any_err = 1'b0; n_at = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (ack != 4'd0) saw_ack = 1'b1;
         if (err != 4'd0) begin
            any_err = 1'b1;
            if (n_at < 0) begin
               n_at = n;
               chk("t5_err_vec", 32'(err), 32'b0100);
               chk("t5_pnv_restored", psc_new_value, INIT);
               chk("t5_idle", 32'(busy), 32'd0);
            end
            req = '0;
         end
      end
      chk("t5_no_ack", 32'(saw_ack), 32'd0);
      if (TMO_EN) begin
         chk("t5_err_cycle", 32'(n_at), 32'(TIMEOUT + 1));
      end else begin
         chk("t5_no_err", 32'(any_err), 32'd0);
         chk("t5_still_busy", 32'(busy), 32'd1);
         chk("t5_pnv_held", psc_new_value, 32'd4);
      end
      req = '0;

      // Two requesters held continuously must alternate.
      do_reset();
      env_psc = 1'b0; run = 1'b1;
      req_value = {32'd0, 32'd22, 32'd0, 32'd11}; req = 4'b0101;
      nids = 0;
      for (int n = 0; n < 400 && nids < 4; n++) begin
         tick_drv = ($urandom_range(0, 2) == 0);
         @(posedge clk); #1;
         if (ack != 4'd0) begin
            ids[nids] = oh2i(ack);
            nids++;
         end
      end
      chk("t6_count", 32'(nids), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < nids) chk($sformatf("t6_order%0d", i), 32'(ids[i]), 32'((i % 2) * 2));
      req = '0; tick_drv = 1'b0;

      // Randomized traffic against the timeline model.
      do_reset();
      env_psc = 1'b0;
      cyc = 0; m_active = 1'b0; m_g = 0; m_id = 0; m_ptr = 0;
      m_ack_cyc = -1; m_err_cyc = -1; m_val = INIT; m_commit = INIT;
      for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; vals[i] = '0; end
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < 4; i++)
            if (pend[i] && i == m_id && (m_ack_cyc == cyc || m_err_cyc == cyc)) pend[i] = 1'b0;
         for (int i = 0; i < 4; i++)
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               vals[i] = $urandom;
            end
         for (int i = 0; i < 4; i++) begin
            req[i] = pend[i];
            req_value[32*i +: 32] = vals[i];
         end
         run      = ($urandom_range(0, 7) != 0);
         tick_drv = (k >= 150 && k < 200) ? 1'b0 : ($urandom_range(0, 2) == 0);
         e_run    = run;

         if (!m_active) begin
            if (req != 4'd0) begin
               for (int j = 0; j < NREQ; j++)
                  if (req[(m_ptr + j) % NREQ]) begin
                     m_id = (m_ptr + j) % NREQ;
                     break;
                  end
               m_active  = 1'b1;
               m_g       = cyc;
               m_val     = vals[m_id];
               m_ptr     = (m_id + 1) % NREQ;
               m_ack_cyc = -1;
            end
         end else if (m_ack_cyc == cyc) begin
            m_active = 1'b0;
         end else if (m_ack_cyc < 0) begin
            if (tick_drv && cyc >= m_g + 2) begin
               m_ack_cyc = cyc + 1;
               m_commit  = m_val;
            end else if (TMO_EN && cyc - m_g >= TIMEOUT) begin
               m_err_cyc = cyc + 1;
               m_val     = m_commit;
               m_active  = 1'b0;
            end
         end

         @(posedge clk); #1;
         cyc++;
         e_oh = 4'd1 << m_id;
         chk("rnd_ack", 32'(ack), (m_ack_cyc == cyc) ? 32'(e_oh) : 32'd0);
         chk("rnd_err", 32'(err), (m_err_cyc == cyc) ? 32'(e_oh) : 32'd0);
         chk("rnd_busy", 32'(busy), 32'(m_active));
         chk("rnd_gid", 32'(grant_id), 32'(m_id));
         chk("rnd_pnv", psc_new_value, m_val);
         chk("rnd_en", 32'(psc_en), 32'(e_run));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
